prio_enc_seg: RTL
=================

Name: prio_enc_seg

Overview:
Parametrised, registered priority encoder with a debounce/stability filter, hold, a change-event counter and four hex seven-segment digit outputs. Successor to the 8-to-3 display encoder on the nvboard npc4 setup: wider input vector, clocked output, glitch rejection and event counting. Drives board switches-to-display demos directly; also usable as a generic "highest request" indicator.

Parameters:
WIDTH, 16, input vector width; power of 2, 2..256.
STABLE_CYC, 4, consecutive identical samples required before commit; >=1.
IDXW (localparam), $clog2(WIDTH), index width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
x  in  WIDTH  request vector.
en  in  1  encoder enable.
hold  in  1  freeze committed outputs.
clr_cnt  in  1  synchronous clear of evt_cnt.
y  out  IDXW  committed index.
valid  out  1  committed value has at least one bit set and en was high.
changed  out  1  one-cycle pulse on each commit.
evt_cnt  out  8  commit counter.
seg0  out  8  hex digit y[3:0].
seg1  out  8  hex digit y[7:4] (zero-extended).
seg2  out  8  hex digit evt_cnt[3:0].
seg3  out  8  hex digit evt_cnt[7:4].

Behaviour:
- Reset (async, immediate, no clock needed): x_q=0, cand_prev=0, stab_cnt=0, y=0, valid=0, changed=0, evt_cnt=0.
- x_q <= x every edge.
- Candidate (combinational from x_q): idx = highest set bit index; any = |x_q; cand = {any, idx}; x_q==0 gives cand = {0,0}.
- Filter: cand_prev <= cand every edge. stab_cnt <= 0 if cand != cand_prev, else saturating increment to STABLE_CYC-1.
- Stable = (cand == cand_prev) and stab_cnt == STABLE_CYC-1. For STABLE_CYC=1, stable whenever cand == cand_prev is not required; cand commits directly.
- Latency: if x is captured into x_q at edge k and held, y/valid update at edge k+STABLE_CYC.
- An x_q value lasting fewer than STABLE_CYC cycles never commits.
- Commit: on an edge with en=1, hold=0, stable, and cand != {valid,y}:
  - {valid,y} <= cand.
  - changed=1 for exactly that cycle; otherwise changed=0.
  - evt_cnt += 1, wrapping 255->0.
- Hold: hold=1 freezes y, valid and evt_cnt, and forces changed=0. The filter keeps running. After hold falls, a stable differing candidate commits on the first edge with hold=0.
- en=0: next edge y=0, valid=0, stab_cnt=0. This overrides hold. No changed pulse, evt_cnt unchanged. After en rises, normal filtering restarts.
- clr_cnt=1: evt_cnt <= 0 next edge. Has priority over a simultaneous increment; changed still pulses.
- Segment encoding: seg[7:1] = a..g, seg[0] = dp, all active-low. Digit patterns for a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- seg0 dp = ~valid. dp is off (1) on seg1..seg3.
- Segments are combinational from registered y/valid/evt_cnt only. After reset: seg0..seg3 = 8'b00000011.

Optional Feature:
PRIO_LSB_EN:
- Defined: idx = lowest set bit index.
- Undefined: idx = highest set bit index (default).
- No other behaviour changes.

Test Plan:
1. Assert rst without clock -> y=0, valid=0, evt_cnt=0, seg0..3=8'b00000011 immediately.
2. (WIDTH=16, STABLE_CYC=4) en=1, x=16'h0A00 held -> y=11 and valid=1 exactly 4 edges after capture; changed high one cycle; evt_cnt=1; seg0=8'b11000000; seg1=8'b00000011.
3. From step 2: x=16'h8000 for 2 cycles, then back to 16'h0A00 -> y stays 11, no changed pulse, evt_cnt=1.
4. hold=1, x=16'h0004 for 10 cycles -> y=11 frozen, changed=0. Drop hold -> next edge y=2, changed pulse, evt_cnt=2.
5. en=0 -> next edge y=0, valid=0, seg0 dp=1, evt_cnt=2. clr_cnt=1 for one cycle -> evt_cnt=0; clr_cnt coincident with a commit -> evt_cnt=0 and changed=1.
6. Drive 256 alternating commits (x toggling 16'h0001/16'h0002, each held 4 cycles) -> evt_cnt wraps to 0 and seg2/seg3 track every value. Assert rst mid-filter -> stab_cnt cleared, no commit.

Source files
------------

// File: rtl/prio_enc_seg_if.sv
// prio_enc_seg_if
//   Bundles the request/control inputs and the committed-result / display
//   outputs of prio_enc_seg. clk and rst are kept as plain module ports.
//
//   Handshake: there is no valid/ready flow control on this block. Inputs are
//   sampled on every rising clock edge. Outputs change only on rising edges.
//   The changed output is a single-cycle strobe that marks an edge on which
//   {valid, y} took a new value.
//
//   Signals (master drives the first group, slave drives the second):
//     x[WIDTH-1:0]   request vector
//     en             encoder enable
//     hold           freeze committed outputs
//     clr_cnt        synchronous clear of evt_cnt
//     y[IDXW-1:0]    committed index
//     valid          committed vector had a bit set (and en was high)
//     changed        one-cycle pulse on each commit
//     evt_cnt[7:0]   commit counter
//     seg0..seg3     active-low seven-segment digits {a..g, dp}
interface prio_enc_seg_if #(
   parameter int WIDTH = 16
);
   localparam int IDXW = $clog2(WIDTH);

   logic [WIDTH-1:0] x;
   logic             en;
   logic             hold;
   logic             clr_cnt;
   logic [IDXW-1:0]  y;
   logic             valid;
   logic             changed;
   logic [7:0]       evt_cnt;
   logic [7:0]       seg0;
   logic [7:0]       seg1;
   logic [7:0]       seg2;
   logic [7:0]       seg3;

   modport master (
      output x, en, hold, clr_cnt,
      input  y, valid, changed, evt_cnt, seg0, seg1, seg2, seg3
   );

   modport slave (
      input  x, en, hold, clr_cnt,
      output y, valid, changed, evt_cnt, seg0, seg1, seg2, seg3
   );
endinterface

// File: rtl/prio_enc_seg.sv
// prio_enc_seg
//   Registered priority encoder with a stability filter, hold, a commit
//   counter and four hex seven-segment digits.
//
//   The input vector is registered, then encoded into a candidate
//   {any, idx}. A candidate is committed to {valid, y} only after it has been
//   seen unchanged for STABLE_CYC consecutive samples. Shorter glitches never
//   reach the outputs.
//
//   Optional build macro: PRIO_LSB_EN. When it is defined, idx is the lowest
//   set bit. When it is undefined (the default), idx is the highest set bit.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   prio_enc_seg_if.slave: x, en, hold, clr_cnt in;
//           y, valid, changed, evt_cnt, seg0..seg3 out
//
//   Parameters: WIDTH (a power of two, 2..256) and STABLE_CYC (>= 1).
module prio_enc_seg #(
   parameter int WIDTH      = 16,
   parameter int STABLE_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   prio_enc_seg_if.slave bus
);
   localparam int IDXW = $clog2(WIDTH);
   localparam int SCW  = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
   localparam logic [SCW-1:0] STAB_MAX = SCW'(STABLE_CYC - 1);

   logic [WIDTH-1:0] x_q;
   logic [IDXW:0]    cand_prev_q;
   logic [SCW-1:0]   stab_cnt_q, stab_cnt_d;
   logic [IDXW-1:0]  y_q, y_d;
   logic             valid_q, valid_d;
   logic             changed_q, changed_d;
   logic [7:0]       evt_cnt_q, evt_cnt_d;

   logic [IDXW-1:0]  idx;
   logic [IDXW:0]    cand;
   logic             stable;
   logic             commit;
   logic [7:0]       y_ext;

   // Priority encode. The last matching iteration wins, so the scan
   // direction selects which end of the vector has priority.
   always_comb begin
      idx = '0;
`ifdef PRIO_LSB_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x_q[i]) idx = IDXW'(i);
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         if (x_q[i]) idx = IDXW'(i);
      end
`endif
   end

   assign cand = {|x_q, idx};

   // The counter saturates at STAB_MAX. Stability is judged on the
   // counter's next value, so the commit lands exactly STABLE_CYC edges
   // after x_q captures a new value.
   always_comb begin
      if (cand != cand_prev_q)       stab_cnt_d = '0;
      else if (stab_cnt_q == STAB_MAX) stab_cnt_d = stab_cnt_q;
      else                           stab_cnt_d = stab_cnt_q + 1'b1;
   end

   assign stable = (STABLE_CYC == 1) ? 1'b1
                 : ((cand == cand_prev_q) && (stab_cnt_d == STAB_MAX));

   assign commit = bus.en && !bus.hold && stable && (cand != {valid_q, y_q});

   always_comb begin
      y_d       = y_q;
      valid_d   = valid_q;
      changed_d = 1'b0;
      evt_cnt_d = evt_cnt_q;
      // Disable overrides hold. It clears the committed value silently.
      if (!bus.en) begin
         y_d     = '0;
         valid_d = 1'b0;
      end else if (commit) begin
         {valid_d, y_d} = cand;
         changed_d      = 1'b1;
         evt_cnt_d      = evt_cnt_q + 8'd1;
      end
      if (bus.clr_cnt) evt_cnt_d = 8'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q         <= '0;
         cand_prev_q <= '0;
         stab_cnt_q  <= '0;
         y_q         <= '0;
         valid_q     <= 1'b0;
         changed_q   <= 1'b0;
         evt_cnt_q   <= 8'd0;
      end else begin
         x_q         <= bus.x;
         cand_prev_q <= cand;
         stab_cnt_q  <= bus.en ? stab_cnt_d : '0;
         y_q         <= y_d;
         valid_q     <= valid_d;
         changed_q   <= changed_d;
         evt_cnt_q   <= evt_cnt_d;
      end
   end

   // Active-low a..g patterns for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 7'b0000001;
         4'h1: hex7 = 7'b1001111;
         4'h2: hex7 = 7'b0010010;
         4'h3: hex7 = 7'b0000110;
         4'h4: hex7 = 7'b1001100;
         4'h5: hex7 = 7'b0100100;
         4'h6: hex7 = 7'b0100000;
         4'h7: hex7 = 7'b0001111;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0000100;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b1100000;
         4'hC: hex7 = 7'b0110001;
         4'hD: hex7 = 7'b1000010;
         4'hE: hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   assign y_ext = 8'(y_q);

   assign bus.y       = y_q;
   assign bus.valid   = valid_q;
   assign bus.changed = changed_q;
   assign bus.evt_cnt = evt_cnt_q;
   assign bus.seg0    = {hex7(y_ext[3:0]), ~valid_q};
   assign bus.seg1    = {hex7(y_ext[7:4]), 1'b1};
   assign bus.seg2    = {hex7(evt_cnt_q[3:0]), 1'b1};
   assign bus.seg3    = {hex7(evt_cnt_q[7:4]), 1'b1};
endmodule
